spike_detection_avalon: RTL and testbench

SPIKE_DETECTION_AVALON -- requirements
Module: spike_detection_avalon

---
 rtl/spike_detection_pkg.sv | 30 +++
 rtl/spike_detector.sv | 121 ++++++++++++
 rtl/spike_detection_avalon.sv | 106 ++++++++++
 tb/tb_spike_detection_avalon.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spike_detection_pkg.sv
// Shared register map, sizing constants and detector state type for the
// spike detection Avalon peripheral.
package spike_detection_pkg;

    localparam int ADDR_W       = 14;
    localparam int DATA_W       = 16;
    localparam int WINDOW_DEPTH = 64;
    localparam int AVG_LEN      = 16;
    localparam int SUM_W        = 20;

    localparam logic [ADDR_W-1:0] ADDR_ID          = 14'd0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL        = 14'd1;
    localparam logic [ADDR_W-1:0] ADDR_STATUS      = 14'd2;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_ACK     = 14'd3;
    localparam logic [ADDR_W-1:0] ADDR_THRESHOLD   = 14'd4;
    localparam logic [ADDR_W-1:0] ADDR_SAMPLE_CNT  = 14'd5;
    localparam logic [ADDR_W-1:0] ADDR_WINDOW_BASE = 14'h1000;

    localparam logic [DATA_W-1:0] ID_VALUE          = 16'h5D1E;
    localparam logic [DATA_W-1:0] DEFAULT_THRESHOLD = 16'h0400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMING,
        ST_DETECT,
        ST_CAPTURE,
        ST_READY
    } det_state_t;

endpackage

// File: rtl/spike_detector.sv
// Sliding-mean spike detector: 16-sample running sum, threshold compare,
// capture FSM and the 64-entry window memory read by the bus decoder.
module spike_detector
    import spike_detection_pkg::*;
#(
    parameter int ERRNO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start,
    input  logic        stop,
    input  logic        ack,
    input  logic [15:0] threshold,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    input  logic [5:0]  win_addr,
    output logic [15:0] win_data,
    output logic        window_ready
);

    localparam logic [4:0] WARM_FULL = 5'(AVG_LEN);
    localparam logic [4:0] WARM_LAST = 5'(AVG_LEN - 1);

    logic [15:0]      hist [AVG_LEN];
    logic [15:0]      mem  [WINDOW_DEPTH];
    logic [SUM_W-1:0] sum;
    logic [4:0]       warm_cnt;
    logic [5:0]       wr_idx;
    det_state_t       state, state_nxt;

    logic             accept;
    logic [SUM_W-1:0] sum_base, sample_ext, oldest_ext;
    logic [4:0]       warm_base;
    logic             warm_done_nxt;
    logic [16:0]      mean17, diff, mag;
    logic             over;
    logic [5:0]       last_idx;
    logic             ack_eff;
    logic             mem_we;
    logic [5:0]       mem_addr;

    // A start in the same cycle as a sample makes that sample the first of a fresh sum.
    assign accept     = sample_valid & enable;
    assign sum_base   = start ? '0 : sum;
    assign sample_ext = {{(SUM_W-16){sample[15]}}, sample};
    assign oldest_ext = start ? '0 : {{(SUM_W-16){hist[AVG_LEN-1][15]}}, hist[AVG_LEN-1]};
    assign warm_base  = start ? '0 : warm_cnt;
    assign warm_done_nxt = (warm_cnt == WARM_FULL) ||
                           (accept && !start && warm_cnt == WARM_LAST);

    // Mean uses the sum before the current sample enters it.
    assign mean17 = {sum[SUM_W-1], sum[SUM_W-1:4]};
    assign diff   = {sample[15], sample} - mean17;
    assign mag    = diff[16] ? (17'd0 - diff) : diff;
    assign over   = (ERRNO == 3) ? (mag >= {1'b0, threshold}) : (mag > {1'b0, threshold});

    assign last_idx = (ERRNO == 2) ? 6'd62 : 6'd63;
    assign ack_eff  = ack && (ERRNO != 1);

    assign mem_we   = accept && ((state == ST_DETECT && over) || state == ST_CAPTURE);
    assign mem_addr = (state == ST_DETECT) ? 6'd0 : wr_idx;

    assign win_data     = mem[win_addr];
    assign window_ready = (state == ST_READY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum      <= '0;
            warm_cnt <= '0;
            for (int i = 0; i < AVG_LEN; i++) hist[i] <= '0;
        end else begin
            if (start) begin
                sum      <= '0;
                warm_cnt <= '0;
                for (int i = 0; i < AVG_LEN; i++) hist[i] <= '0;
            end
            if (accept) begin
                sum     <= sum_base + sample_ext - oldest_ext;
                hist[0] <= sample;
                for (int i = 1; i < AVG_LEN; i++) hist[i] <= start ? '0 : hist[i-1];
                if (warm_base != WARM_FULL) warm_cnt <= warm_base + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            wr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (mem_we) wr_idx <= (state == ST_DETECT) ? 6'd1 : wr_idx + 6'd1;
        end
    end

    // Window contents are deliberately left without reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= sample;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (start) state_nxt = ST_ARMING;
            ST_ARMING:  if (stop) state_nxt = ST_IDLE;
                        else if (warm_done_nxt) state_nxt = ST_DETECT;
            ST_DETECT:  if (stop) state_nxt = ST_IDLE;
                        else if (accept && over) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (stop) state_nxt = ST_IDLE;
                        else if (accept && wr_idx == last_idx) state_nxt = ST_READY;
            ST_READY:   if (ack_eff) begin
                            if (!enable) state_nxt = ST_IDLE;
                            else if (warm_done_nxt) state_nxt = ST_DETECT;
                            else state_nxt = ST_ARMING;
                        end
            default:    state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/spike_detection_avalon.sv
// Avalon-MM register front end for the spike detector. Defining
// SPIKE_DET_SAMPLE_COUNTER_EN adds the SAMPLE_CNT register at address 5.
module spike_detection_avalon
    import spike_detection_pkg::*;
#(
    parameter int ERRNO = 0
) (
    input  logic        avl_clk_i,
    input  logic        avl_reset_i,
    input  logic [13:0] avl_address_i,
    input  logic [3:0]  avl_byteenable_i,
    input  logic        avl_write_i,
    input  logic [15:0] avl_writedata_i,
    input  logic        avl_read_i,
    output logic        avl_readdatavalid_o,
    output logic [15:0] avl_readdata_o,
    output logic        avl_waitrequest_o,
    output logic        avl_irq_o,
    input  logic [15:0] sample_i,
    input  logic        sample_valid_i
);

    logic        ctrl_en;
    logic [15:0] threshold;
    logic        wr_ctrl, enable_eff, start, stop, ack;
    logic [15:0] win_data, rd_mux;
    logic        window_ready;
    logic        unused_byteenable;

    assign unused_byteenable = ^avl_byteenable_i;
    assign avl_waitrequest_o = 1'b0;
    assign avl_irq_o         = window_ready;

    // The bus write wins: the detector sees the enable as it stands after this write.
    assign wr_ctrl    = avl_write_i && avl_address_i == ADDR_CTRL;
    assign enable_eff = wr_ctrl ? avl_writedata_i[0] : ctrl_en;
    assign start      = wr_ctrl && avl_writedata_i[0] && !ctrl_en;
    assign stop       = wr_ctrl && !avl_writedata_i[0];
    assign ack        = avl_write_i && avl_address_i == ADDR_IRQ_ACK;

    spike_detector #(.ERRNO(ERRNO)) u_detector (
        .clk          (avl_clk_i),
        .rst          (avl_reset_i),
        .enable       (enable_eff),
        .start        (start),
        .stop         (stop),
        .ack          (ack),
        .threshold    (threshold),
        .sample       (sample_i),
        .sample_valid (sample_valid_i),
        .win_addr     (avl_address_i[5:0]),
        .win_data     (win_data),
        .window_ready (window_ready)
    );

    always_ff @(posedge avl_clk_i or posedge avl_reset_i) begin
        if (avl_reset_i) begin
            ctrl_en   <= 1'b0;
            threshold <= DEFAULT_THRESHOLD;
        end else if (avl_write_i) begin
            if (avl_address_i == ADDR_CTRL)      ctrl_en   <= avl_writedata_i[0];
            if (avl_address_i == ADDR_THRESHOLD) threshold <= avl_writedata_i;
        end
    end

`ifdef SPIKE_DET_SAMPLE_COUNTER_EN
    logic [15:0] sample_cnt;

    always_ff @(posedge avl_clk_i or posedge avl_reset_i) begin
        if (avl_reset_i) begin
            sample_cnt <= '0;
        end else if (start) begin
            sample_cnt <= sample_valid_i ? 16'd1 : 16'd0;
        end else if (sample_valid_i && enable_eff) begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (avl_address_i)
            ADDR_ID:        rd_mux = ID_VALUE;
            ADDR_CTRL:      rd_mux = {15'd0, ctrl_en};
            ADDR_STATUS:    rd_mux = {14'd0, window_ready, ctrl_en};
            ADDR_THRESHOLD: rd_mux = threshold;
`ifdef SPIKE_DET_SAMPLE_COUNTER_EN
            ADDR_SAMPLE_CNT: rd_mux = sample_cnt;
`endif
            default: begin
                if (avl_address_i[13:6] == ADDR_WINDOW_BASE[13:6]) rd_mux = win_data;
            end
        endcase
    end

    always_ff @(posedge avl_clk_i or posedge avl_reset_i) begin
        if (avl_reset_i) begin
            avl_readdatavalid_o <= 1'b0;
            avl_readdata_o      <= '0;
        end else begin
            avl_readdatavalid_o <= avl_read_i;
            avl_readdata_o      <= avl_read_i ? rd_mux : 16'd0;
        end
    end

endmodule

// File: tb/tb_spike_detection_avalon.sv
// Self-checking bench for spike_detection_avalon: register table, then
// hand-written acquisition, capture, boundary, acknowledge and abort sequences.
module tb_spike_detection_avalon;

    logic        avl_clk_i = 1'b0;
    logic        avl_reset_i;
    logic [13:0] avl_address_i;
    logic [3:0]  avl_byteenable_i;
    logic        avl_write_i;
    logic [15:0] avl_writedata_i;
    logic        avl_read_i;
    logic        avl_readdatavalid_o;
    logic [15:0] avl_readdata_o;
    logic        avl_waitrequest_o;
    logic        avl_irq_o;
    logic [15:0] sample_i;
    logic        sample_valid_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] value;
        string       name;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    rd_exp_t exp_item;

    typedef struct {
        logic        wr;
        logic [13:0] addr;
        logic [15:0] data;
        logic [15:0] expv;
        string       name;
    } vec_t;

    vec_t vecs[19];

    spike_detection_avalon dut (
        .avl_clk_i           (avl_clk_i),
        .avl_reset_i         (avl_reset_i),
        .avl_address_i       (avl_address_i),
        .avl_byteenable_i    (avl_byteenable_i),
        .avl_write_i         (avl_write_i),
        .avl_writedata_i     (avl_writedata_i),
        .avl_read_i          (avl_read_i),
        .avl_readdatavalid_o (avl_readdatavalid_o),
        .avl_readdata_o      (avl_readdata_o),
        .avl_waitrequest_o   (avl_waitrequest_o),
        .avl_irq_o           (avl_irq_o),
        .sample_i            (sample_i),
        .sample_valid_i      (sample_valid_i)
    );

    always #5 avl_clk_i = ~avl_clk_i;

    task automatic tick();
        @(posedge avl_clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: every read pushes its expectation, popped when data comes back.
    always @(negedge avl_clk_i) begin
        if (avl_readdatavalid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected readdatavalid: got data 0x%0h, expected no response", avl_readdata_o);
            end else begin
                exp_item = exp_q.pop_front();
                checkOutput(exp_item.name, {16'd0, avl_readdata_o}, {16'd0, exp_item.value});
            end
        end
    end

    task automatic busWrite(input logic [13:0] addr, input logic [15:0] data);
        avl_address_i   = addr;
        avl_writedata_i = data;
        avl_write_i     = 1'b1;
        tick();
        avl_write_i     = 1'b0;
    endtask

    task automatic busRead(input string name, input logic [13:0] addr, input logic [15:0] expv);
        rd_exp_t e;
        e.value = expv;
        e.name  = name;
        exp_q.push_back(e);
        avl_address_i = addr;
        avl_read_i    = 1'b1;
        tick();
        avl_read_i    = 1'b0;
        checkOutput({name, " rdv high"}, {31'd0, avl_readdatavalid_o}, 32'd1);
        tick();
        checkOutput({name, " rdv one cycle"}, {31'd0, avl_readdatavalid_o}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [15:0] value);
        sample_i       = value;
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
    endtask

    task automatic feedMany(input logic [15:0] value, input int n);
        for (int i = 0; i < n; i++) applyStimulus(value);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, 14'h0000, 16'h0000, 16'h5D1E, "id"};
        vecs[1]  = '{1'b0, 14'h0004, 16'h0000, 16'h0400, "threshold reset"};
        vecs[2]  = '{1'b0, 14'h0001, 16'h0000, 16'h0000, "ctrl reset"};
        vecs[3]  = '{1'b0, 14'h0002, 16'h0000, 16'h0000, "status reset"};
        vecs[4]  = '{1'b0, 14'h0003, 16'h0000, 16'h0000, "irq_ack reads zero"};
        vecs[5]  = '{1'b0, 14'h0005, 16'h0000, 16'h0000, "addr5 after reset"};
        vecs[6]  = '{1'b0, 14'h0006, 16'h0000, 16'h0000, "unmapped 6"};
        vecs[7]  = '{1'b0, 14'h0FFF, 16'h0000, 16'h0000, "unmapped 0x0FFF"};
        vecs[8]  = '{1'b0, 14'h1040, 16'h0000, 16'h0000, "unmapped 0x1040"};
        vecs[9]  = '{1'b1, 14'h0004, 16'h1234, 16'h0000, "wr threshold"};
        vecs[10] = '{1'b0, 14'h0004, 16'h0000, 16'h1234, "threshold rw"};
        vecs[11] = '{1'b1, 14'h0000, 16'h0000, 16'h0000, "wr id"};
        vecs[12] = '{1'b0, 14'h0000, 16'h0000, 16'h5D1E, "id read-only"};
        vecs[13] = '{1'b1, 14'h0002, 16'h0003, 16'h0000, "wr status"};
        vecs[14] = '{1'b0, 14'h0002, 16'h0000, 16'h0000, "status read-only"};
        vecs[15] = '{1'b1, 14'h0001, 16'h0002, 16'h0000, "wr ctrl bit1"};
        vecs[16] = '{1'b0, 14'h0001, 16'h0000, 16'h0000, "ctrl bit0 only"};
        vecs[17] = '{1'b1, 14'h0004, 16'h0400, 16'h0000, "restore threshold"};
        vecs[18] = '{1'b0, 14'h0004, 16'h0000, 16'h0400, "threshold restored"};

        avl_reset_i      = 1'b1;
        avl_address_i    = '0;
        avl_byteenable_i = 4'hF;
        avl_write_i      = 1'b0;
        avl_writedata_i  = '0;
        avl_read_i       = 1'b0;
        sample_i         = '0;
        sample_valid_i   = 1'b0;
        tick();
        tick();
        avl_reset_i = 1'b0;
        tick();

        checkOutput("reset irq", {31'd0, avl_irq_o}, 32'd0);
        checkOutput("reset readdatavalid", {31'd0, avl_readdatavalid_o}, 32'd0);
        checkOutput("reset readdata", {16'd0, avl_readdata_o}, 32'd0);
        checkOutput("reset waitrequest", {31'd0, avl_waitrequest_o}, 32'd0);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].wr) busWrite(vecs[i].addr, vecs[i].data);
            else            busRead(vecs[i].name, vecs[i].addr, vecs[i].expv);
        end

        // Steady input never spikes
        busWrite(14'd1, 16'd1);
        feedMany(16'd100, 100);
        checkOutput("steady irq", {31'd0, avl_irq_o}, 32'd0);
        busRead("steady status", 14'd2, 16'd1);

        // Single spike fills the window after 64 samples
        busWrite(14'd1, 16'd0);
        busWrite(14'd1, 16'd1);
        feedMany(16'd0, 20);
        applyStimulus(16'd2000);
        feedMany(16'd0, 62);
        checkOutput("irq before 64th", {31'd0, avl_irq_o}, 32'd0);
        applyStimulus(16'd0);
        checkOutput("irq after 64th", {31'd0, avl_irq_o}, 32'd1);
        busRead("status ready", 14'd2, 16'd3);
        for (int i = 0; i < 64; i++)
            busRead($sformatf("window[%0d]", i), 14'h1000 + 14'(i), (i == 0) ? 16'd2000 : 16'd0);

        // Acknowledge, then a negative spike raises the IRQ again
        busWrite(14'd3, 16'd0);
        checkOutput("irq after ack", {31'd0, avl_irq_o}, 32'd0);
        busRead("status after ack", 14'd2, 16'd1);
        feedMany(16'd0, 16);
        applyStimulus(16'hF448);
        feedMany(16'd0, 63);
        checkOutput("irq second spike", {31'd0, avl_irq_o}, 32'd1);
        busRead("window[0] negative", 14'h1000, 16'hF448);
        busWrite(14'd3, 16'd0);
        checkOutput("irq second ack", {31'd0, avl_irq_o}, 32'd0);

        // Threshold boundary: mean 200 -> 1224 is equal (no spike); mean 264 -> 1289 exceeds by one
        feedMany(16'd200, 16);
        applyStimulus(16'd1224);
        applyStimulus(16'd1289);
        feedMany(16'd200, 62);
        checkOutput("boundary equal no spike", {31'd0, avl_irq_o}, 32'd0);
        applyStimulus(16'd200);
        checkOutput("boundary over spike", {31'd0, avl_irq_o}, 32'd1);
        busRead("boundary window[0]", 14'h1000, 16'd1289);
        busRead("boundary window[1]", 14'h1001, 16'd200);
        busWrite(14'd3, 16'd0);

        // Abort mid-capture, restart: warm-up must begin again
        feedMany(16'd0, 16);
        applyStimulus(16'd3000);
        feedMany(16'd0, 10);
        busWrite(14'd1, 16'd0);
        busWrite(14'd1, 16'd1);
        feedMany(16'd0, 9);
        applyStimulus(16'd8000);
        checkOutput("restart irq", {31'd0, avl_irq_o}, 32'd0);
        busRead("restart status", 14'd2, 16'd1);
        feedMany(16'd0, 63);
        checkOutput("no capture after restart", {31'd0, avl_irq_o}, 32'd0);

        tick();
        tick();
        checkOutput("scoreboard drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
